// File: rtl/serial_sub_16bit_if.sv
// Operand/result bundle for serial_sub_16bit; master drives the request, slave returns the result.
// Optional ovf signal present only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_16bit_if #(
    parameter int N_NIB = 4
);
    localparam int W = 4 * N_NIB;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bout;
    logic         busy;
    logic         done;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;

    modport master (output start, a, b, bin, input d, bout, busy, done, ovf);
    modport slave  (input start, a, b, bin, output d, bout, busy, done, ovf);
`else
    modport master (output start, a, b, bin, input d, bout, busy, done);
    modport slave  (input start, a, b, bin, output d, bout, busy, done);
`endif
endinterface

// File: rtl/serial_sub_16bit.sv
// Nibble-serial subtractor: d = a - b - bin using one reused 4-bit slice, LSB nibble first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module sub4_slice (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_bi,
    output logic [3:0] o_d,
    output logic       o_bo
);
    // Bit 4 of the 5-bit difference goes high exactly when the nibble result is negative.
    assign {o_bo, o_d} = {1'b0, i_a} - {1'b0, i_b} - {4'b0000, i_bi};
endmodule

module serial_sub_16bit #(
    parameter int N_NIB = 4
) (
    input logic                    clk,
    input logic                    rst,
    serial_sub_16bit_if.slave      bus
);
    localparam int W     = 4 * N_NIB;
    localparam int CNT_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_bin;
    logic [CNT_W-1:0] r_cnt;
    logic             r_borrow;
    logic [W-1:0]     r_d;
    logic             r_bout;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic             w_bi;
    logic [3:0]       w_slice_d;
    logic             w_slice_bo;
    logic             w_last;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_ovf;
`endif

    assign w_last = (r_cnt == CNT_W'(N_NIB - 1));
    assign w_bi   = (r_cnt == '0) ? r_bin : r_borrow;

    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int unsigned i = 0; i < N_NIB; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_a_nib = r_a[4*i +: 4];
                w_b_nib = r_b[4*i +: 4];
            end
        end
    end

    sub4_slice u_slice (
        .i_a  (w_a_nib),
        .i_b  (w_b_nib),
        .i_bi (w_bi),
        .o_d  (w_slice_d),
        .o_bo (w_slice_bo)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next_state = RUN;
            RUN:     if (w_last)    w_next_state = DONE;
            DONE:                   w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_bin    <= 1'b0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_d      <= '0;
            r_bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && bus.start) begin
                r_a   <= bus.a;
                r_b   <= bus.b;
                r_bin <= bus.bin;
                r_cnt <= '0;
            end
            if (r_state == RUN) begin
                for (int unsigned i = 0; i < N_NIB; i++) begin
                    if (r_cnt == CNT_W'(i)) r_d[4*i +: 4] <= w_slice_d;
                end
                r_borrow <= w_slice_bo;
                r_cnt    <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_bout <= w_slice_bo;
`ifdef SERIAL_SUB_OVF_EN
                    r_ovf  <= (r_a[W-1] != r_b[W-1]) && (w_slice_d[3] != r_a[W-1]);
`endif
                end
            end
        end
    end

    assign bus.d    = r_d;
    assign bus.bout = r_bout;
    assign bus.busy = (r_state != IDLE);
    assign bus.done = (r_state == DONE);
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = r_ovf;
`endif
endmodule
